// File: rtl/dual_rail_pkg.sv
// Shared types for the dual-rail receiver: FSM states and {t,f} rail encodings.
package dual_rail_pkg;

  typedef enum logic [1:0] {
    S_INIT = 2'd0,
    S_IDLE = 2'd1,
    S_ACK  = 2'd2,
    S_ERR  = 2'd3
  } state_e;

  localparam logic [1:0] SPACER  = 2'b00;
  localparam logic [1:0] ONE     = 2'b10;
  localparam logic [1:0] ZERO    = 2'b01;
  localparam logic [1:0] ILLEGAL = 2'b11;

endpackage

// File: rtl/dual_rail_pair_decode.sv
// Classifies one {t,f} rail pair as spacer, logic one, logic zero or illegal.
module dual_rail_pair_decode
  import dual_rail_pkg::*;
(
  input  logic i_t,
  input  logic i_f,
  output logic o_spacer,
  output logic o_illegal,
  output logic o_bit
);

  always_comb begin
    o_spacer  = 1'b0;
    o_illegal = 1'b0;
    o_bit     = 1'b0;
    case ({i_t, i_f})
      SPACER:  o_spacer  = 1'b1;
      ONE:     o_bit     = 1'b1;
      ZERO:    o_bit     = 1'b0;
      ILLEGAL: o_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/dual_rail_receiver.sv
// Four-phase dual-rail receiver: captures complete codewords, acknowledges,
// and flags illegal pairs, stalled partial words and non-monotonic returns.
//   state  | meaning
//   S_INIT | after reset, waiting for a genuinely observed all-spacer word
//   S_IDLE | ack low, waiting for a complete codeword
//   S_ACK  | codeword captured, ack high, waiting for the return to spacer
//   S_ERR  | protocol violation, err high until an all-spacer word
module dual_rail_receiver
  import dual_rail_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d_t,
  input  logic [WIDTH-1:0] d_f,
  input  logic             clr,
  output logic [WIDTH-1:0] data,
  output logic             valid,
  output logic             ack,
  output logic             err,
  output logic [CNT_W-1:0] err_cnt
);

  localparam int TCW = $clog2(TIMEOUT + 1);
  localparam logic [TCW-1:0]   TC_LAST = TCW'(TIMEOUT - 1);
  localparam logic [TCW-1:0]   TC_ONE  = TCW'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [WIDTH-1:0] r_t, r_f, r_data;
  logic [WIDTH-1:0] w_spacer, w_illegal, w_bit;
  logic [TCW-1:0]   r_tcnt;
  logic [CNT_W-1:0] r_err_cnt;
  logic             r_primed, r_valid, r_ack, r_err;
  state_e           r_state;

  logic w_all_spacer, w_any_illegal, w_complete, w_partial, w_ack_bad, w_err_entry;

  for (genvar i = 0; i < WIDTH; i++) begin : g_pair
    dual_rail_pair_decode u_dec (
      .i_t      (r_t[i]),
      .i_f      (r_f[i]),
      .o_spacer (w_spacer[i]),
      .o_illegal(w_illegal[i]),
      .o_bit    (w_bit[i])
    );
  end

  assign w_all_spacer  = &w_spacer;
  assign w_any_illegal = |w_illegal;
  assign w_complete    = ~|w_spacer & ~w_any_illegal;
  assign w_partial     = ~w_all_spacer & ~w_complete & ~w_any_illegal;
  // In S_ACK a pair may fall back to spacer, but never flip to the other value.
  assign w_ack_bad     = w_any_illegal | (|(~w_spacer & (w_bit ^ r_data)));

  always_comb begin
    w_err_entry = 1'b0;
    case (r_state)
      S_IDLE:  w_err_entry = w_any_illegal | (w_partial & (r_tcnt == TC_LAST));
      S_ACK:   w_err_entry = w_ack_bad;
      default: w_err_entry = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_INIT;
      r_t      <= '0;
      r_f      <= '0;
      r_primed <= 1'b0;
      r_data   <= '0;
      r_valid  <= 1'b0;
      r_ack    <= 1'b0;
      r_err    <= 1'b0;
      r_tcnt   <= '0;
    end else begin
      r_t      <= d_t;
      r_f      <= d_f;
      r_primed <= 1'b1;
      r_valid  <= 1'b0;
      r_tcnt   <= '0;
      case (r_state)
        // r_primed blocks the reset value of r_t/r_f from counting as a spacer.
        S_INIT: if (r_primed && w_all_spacer) r_state <= S_IDLE;
        S_IDLE: begin
          if (w_err_entry) begin
            r_state <= S_ERR;
            r_err   <= 1'b1;
          end else if (w_complete) begin
            r_data  <= r_t;
            r_valid <= 1'b1;
            r_ack   <= 1'b1;
            r_state <= S_ACK;
          end else if (w_partial) begin
            r_tcnt <= r_tcnt + TC_ONE;
          end
        end
        S_ACK: begin
          if (w_err_entry) begin
            r_state <= S_ERR;
            r_err   <= 1'b1;
            r_ack   <= 1'b0;
          end else if (w_all_spacer) begin
            r_state <= S_IDLE;
            r_ack   <= 1'b0;
          end
        end
        S_ERR: begin
          if (w_all_spacer) begin
            r_state <= S_IDLE;
            r_err   <= 1'b0;
          end
        end
        default: r_state <= S_INIT;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err_cnt <= '0;
    end else if (clr) begin
      r_err_cnt <= '0;
    end else if (w_err_entry && (r_err_cnt != CNT_MAX)) begin
      r_err_cnt <= r_err_cnt + CNT_ONE;
    end
  end

  assign data    = r_data;
  assign valid   = r_valid;
  assign ack     = r_ack;
  assign err     = r_err;
  assign err_cnt = r_err_cnt;

endmodule

// File: tb/tb_dual_rail_receiver.sv
// Directed scenarios plus randomized traffic against a word-level protocol model.
module tb_dual_rail_receiver;

  localparam int W  = 4;
  localparam int TO = 16;
  localparam int CW = 2;
  localparam int CNT_SAT = (1 << CW) - 1;

  localparam int PH_WAIT  = 0;
  localparam int PH_READY = 1;
  localparam int PH_HOLD  = 2;
  localparam int PH_FAULT = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          clr = 1'b0;
  logic [W-1:0]  d_t = '0;
  logic [W-1:0]  d_f = '0;
  logic [W-1:0]  data;
  logic          valid, ack, err;
  logic [CW-1:0] err_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  int           m_phase = PH_WAIT;
  bit           m_seen  = 1'b0;
  logic [W-1:0] m_rt = '0, m_rf = '0, m_data = '0;
  int           m_tc = 0, m_errs = 0;
  bit           m_valid = 1'b0, m_ack = 1'b0;

  always #5 clk = ~clk;

  dual_rail_receiver #(.WIDTH(W), .TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk    (clk),
    .rst    (rst),
    .d_t    (d_t),
    .d_f    (d_f),
    .clr    (clr),
    .data   (data),
    .valid  (valid),
    .ack    (ack),
    .err    (err),
    .err_cnt(err_cnt)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".valid"},   8'(valid),   8'(m_valid));
    chk({tag, ".ack"},     8'(ack),     8'(m_ack));
    chk({tag, ".err"},     8'(err),     8'(m_phase == PH_FAULT));
    chk({tag, ".err_cnt"}, 8'(err_cnt), 8'(m_errs));
    if (m_ack) chk({tag, ".data"}, 8'(data), 8'(m_data));
  endtask

  // One clock edge of the protocol, judged on the previously registered word.
  task automatic model_edge(input logic c);
    logic [W-1:0] occ, bad, diff;
    bit e;
    occ = m_rt | m_rf;
    bad = m_rt & m_rf;
    e = 1'b0;
    m_valid = 1'b0;
    case (m_phase)
      PH_WAIT: if (m_seen && occ == '0) m_phase = PH_READY;
      PH_READY: begin
        if (bad != '0) e = 1'b1;
        else if (&occ) begin
          m_data = m_rt; m_valid = 1'b1; m_ack = 1'b1; m_phase = PH_HOLD; m_tc = 0;
        end else if (occ == '0) m_tc = 0;
        else begin
          m_tc++;
          if (m_tc == TO) e = 1'b1;
        end
      end
      PH_HOLD: begin
        diff = (m_rt ^ m_data) & occ;
        if (bad != '0 || diff != '0) e = 1'b1;
        else if (occ == '0) begin m_ack = 1'b0; m_phase = PH_READY; end
      end
      default: if (occ == '0) m_phase = PH_READY;
    endcase
    if (e) begin m_phase = PH_FAULT; m_ack = 1'b0; m_tc = 0; end
    if (c) m_errs = 0;
    else if (e && m_errs < CNT_SAT) m_errs++;
    m_rt = d_t;
    m_rf = d_f;
    m_seen = 1'b1;
  endtask

  task automatic step(input logic [W-1:0] t, input logic [W-1:0] f, input logic c, input string tag);
    d_t = t; d_f = f; clr = c;
    @(posedge clk);
    model_edge(c);
    #1;
    check_all(tag);
  endtask

  task automatic pulse_reset(input string tag);
    rst = 1'b1;
    #2;
    chk({tag, ".valid"},   8'(valid),   8'h00);
    chk({tag, ".ack"},     8'(ack),     8'h00);
    chk({tag, ".err"},     8'(err),     8'h00);
    chk({tag, ".err_cnt"}, 8'(err_cnt), 8'h00);
    chk({tag, ".data"},    8'(data),    8'h00);
    @(posedge clk);
    #1;
    rst = 1'b0;
    m_phase = PH_WAIT; m_seen = 1'b0; m_rt = '0; m_rf = '0; m_data = '0;
    m_tc = 0; m_errs = 0; m_valid = 1'b0; m_ack = 1'b0;
  endtask

  task automatic err_pulse(input string tag);
    step(4'b0001, 4'b0001, 1'b0, tag);
    step(4'b0000, 4'b0000, 1'b0, tag);
    step(4'b0000, 4'b0000, 1'b0, tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] t, f, m, last_t, last_f;
    int k;
    #12;
    pulse_reset("por");

    // normal handshake
    step(4'h0, 4'h0, 1'b0, "hs.sp");
    step(4'h0, 4'h0, 1'b0, "hs.sp");
    step(4'hA, 4'h5, 1'b0, "hs.cw");
    step(4'hA, 4'h5, 1'b0, "hs.cap");
    chk("hs.valid_pulse", 8'(valid), 8'h01);
    chk("hs.data_a",      8'(data),  8'h0A);
    step(4'hA, 4'h5, 1'b0, "hs.hold");
    chk("hs.valid_once",  8'(valid), 8'h00);
    step(4'h2, 4'h1, 1'b0, "hs.partret");
    step(4'h0, 4'h0, 1'b0, "hs.ret");
    step(4'h0, 4'h0, 1'b0, "hs.idle");
    chk("hs.ack_low", 8'(ack), 8'h00);

    // illegal pair from idle
    step(4'b0001, 4'b0001, 1'b0, "ill.in");
    step(4'b0001, 4'b0001, 1'b0, "ill.err");
    chk("ill.err_hi", 8'(err),     8'h01);
    chk("ill.cnt1",   8'(err_cnt), 8'h01);
    step(4'h0, 4'h0, 1'b0, "ill.sp");
    step(4'h0, 4'h0, 1'b0, "ill.exit");
    chk("ill.err_lo", 8'(err), 8'h00);

    // partial word held until timeout
    for (int i = 1; i <= TO + 1; i++) begin
      step(4'b0011, 4'b0000, 1'b0, "to.hold");
      chk("to.err_at_timeout", 8'(err), 8'((i == TO + 1) ? 1 : 0));
    end
    chk("to.cnt2", 8'(err_cnt), 8'h02);
    step(4'h0, 4'h0, 1'b0, "to.sp");
    step(4'h0, 4'h0, 1'b0, "to.exit");

    // non-monotonic change while acknowledged
    step(4'hA, 4'h5, 1'b0, "nm.cw");
    step(4'hA, 4'h5, 1'b0, "nm.cap");
    step(4'h5, 4'hA, 1'b0, "nm.flip");
    step(4'h5, 4'hA, 1'b0, "nm.err");
    chk("nm.err_hi", 8'(err), 8'h01);
    chk("nm.ack_lo", 8'(ack), 8'h00);
    step(4'h0, 4'h0, 1'b0, "nm.sp");
    step(4'h0, 4'h0, 1'b0, "nm.exit");

    // reset while acknowledged with the codeword still held
    step(4'h6, 4'h9, 1'b0, "rh.cw");
    step(4'h6, 4'h9, 1'b0, "rh.cap");
    chk("rh.ack_hi", 8'(ack), 8'h01);
    pulse_reset("rh.rst");
    for (int i = 0; i < 4; i++) begin
      step(4'h6, 4'h9, 1'b0, "rh.held");
      chk("rh.no_valid", 8'(valid), 8'h00);
    end
    step(4'h0, 4'h0, 1'b0, "rh.sp");
    step(4'h0, 4'h0, 1'b0, "rh.sp");
    step(4'hC, 4'h3, 1'b0, "rh.cw2");
    step(4'hC, 4'h3, 1'b0, "rh.cap2");
    chk("rh.valid_new", 8'(valid), 8'h01);
    chk("rh.data_c",    8'(data),  8'h0C);
    step(4'h0, 4'h0, 1'b0, "rh.ret");
    step(4'h0, 4'h0, 1'b0, "rh.idle");

    // saturation and clear
    for (int i = 0; i < 4; i++) err_pulse("sat.err");
    chk("sat.cnt3", 8'(err_cnt), 8'h03);
    step(4'h0, 4'h0, 1'b1, "sat.clr");
    chk("sat.cleared", 8'(err_cnt), 8'h00);
    err_pulse("sat.err1");
    chk("sat.cnt1", 8'(err_cnt), 8'h01);
    step(4'b0100, 4'b0100, 1'b0, "sat.ill");
    step(4'h0, 4'h0, 1'b1, "sat.clr_err");
    chk("sat.clr_wins_err", 8'(err),     8'h01);
    chk("sat.clr_wins_cnt", 8'(err_cnt), 8'h00);
    step(4'h0, 4'h0, 1'b0, "sat.exit");

    // randomized traffic
    last_t = 4'hA; last_f = 4'h5;
    for (int n = 0; n < 400; n++) begin
      k = int'($urandom_range(0, 9));
      case (k)
        0, 1, 2: begin t = '0; f = '0; end
        3, 4, 5: begin t = 4'($urandom); f = ~t; last_t = t; last_f = f; end
        6: begin m = 4'($urandom); t = 4'($urandom) & m; f = ~t & m; end
        7: begin t = 4'($urandom); f = ~t; f[$urandom_range(0, W - 1)] = 1'b1; t = t | f; end
        8: begin m = 4'($urandom); t = last_t & m; f = last_f & m; end
        default: begin t = d_t; f = d_f; end
      endcase
      step(t, f, ($urandom_range(0, 15) == 0), "rnd");
      if ($urandom_range(0, 149) == 0) pulse_reset("rnd.rst");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/dual_rail_receiver.md
DUAL_RAIL_RECEIVER -- requirements
Module: dual_rail_receiver

Interface
REQ-001 Parameter WIDTH, default 8: number of dual-rail bit pairs.
REQ-002 Parameter TIMEOUT, default 16: maximum cycles a partial codeword may persist before an error is declared.
REQ-003 Parameter CNT_W, default 8: width of the error counter.
REQ-004 The block SHALL use one clock; reset is asynchronous and active-high.
REQ-005 clk  input  1  rising-edge clock.
REQ-006 rst  input  1  asynchronous active-high reset.
REQ-007 d_t  input  WIDTH  true rails, synchronous to clk.
REQ-008 d_f  input  WIDTH  false rails, synchronous to clk.
REQ-009 clr  input  1  synchronous clear of err_cnt.
REQ-010 data  output  WIDTH  decoded single-rail word, valid while ack=1.
REQ-011 valid  output  1  one-cycle pulse when a codeword is captured.
REQ-012 ack  output  1  four-phase completion signal to the sender.
REQ-013 err  output  1  high while the block is in the error state.
REQ-014 err_cnt  output  CNT_W  saturating count of error-state entries.

Function
REQ-015 Each bit pair SHALL be decoded as (t,f) = 00 spacer, 10 logic 1, 01 logic 0, and 11 illegal.
REQ-016 d_t and d_f SHALL be registered once; all decisions use the registered pair, and all outputs are registered.
REQ-017 Latency: a codeword stable before edge k SHALL produce valid=1, ack=1, and updated data after edge k+1.
REQ-018 The FSM SHALL have exactly the states S_INIT, S_IDLE, S_ACK, and S_ERR.
REQ-019 S_INIT: ack=0 and codewords are ignored; an all-spacer word SHALL move the FSM to S_IDLE.
REQ-020 S_IDLE, any illegal pair: SHALL go to S_ERR.
REQ-021 S_IDLE, all pairs valid: SHALL capture data, pulse valid, and go to S_ACK.
REQ-022 S_IDLE, some but not all pairs non-spacer: SHALL increment a timeout counter.
REQ-023 S_IDLE timeout: when the timeout counter reaches TIMEOUT, the FSM SHALL go to S_ERR.
REQ-024 S_IDLE, all-spacer: SHALL keep the timeout counter at 0.
REQ-025 S_ACK: ack=1 and data is held; a partially returned spacer is legal.
REQ-026 S_ACK, all-spacer: SHALL go to S_IDLE with ack=0 on the next edge.
REQ-027 S_ACK, any pair that is illegal or differs from the captured value without being spacer: SHALL go to S_ERR.
REQ-028 On every entry to S_ERR, err SHALL be 1 and ack SHALL be 0.
REQ-029 S_ERR SHALL exit to S_IDLE only after one all-spacer cycle.
REQ-030 err_cnt SHALL increment by 1 on each entry to S_ERR and saturate at 2^CNT_W-1.
REQ-031 When clr coincides with an error entry, clr SHALL win and err_cnt SHALL become 0.
REQ-032 valid SHALL never assert in S_INIT or S_ERR, and never on two consecutive cycles.

Reset
REQ-033 While rst=1, the block SHALL force state to S_INIT and data, valid, ack, err, err_cnt, the timeout counter, and the input register to 0, independent of clk.
REQ-034 After a reset mid-handshake, a codeword still held by the sender SHALL NOT be captured until a spacer has been observed.

Structure
REQ-035 Package dual_rail_pkg SHALL hold the FSM state enum and the rail-encoding constants SPACER, ONE, ZERO, and ILLEGAL.
REQ-036 Per-pair classification (spacer/one/zero/illegal) SHALL be a combinational sub-module, dual_rail_pair_decode, instantiated WIDTH times.

Verification (WIDTH=4, TIMEOUT=16, CNT_W=2)
REQ-037 Scenario, normal handshake: spacer, then d_t=1010, d_f=0101 -> valid pulse, data=4'hA, ack=1; then spacer -> ack=0, back in S_IDLE.
REQ-038 Scenario, illegal pair: from S_IDLE, d_t=0001, d_f=0001 -> err=1, err_cnt=1, no valid; then spacer -> err=0.
REQ-039 Scenario, partial-codeword timeout: d_t=0011, d_f=0000 held -> err=1 exactly at the timeout, err_cnt increments, no valid.
REQ-040 Scenario, non-monotonic change in S_ACK: after capturing 4'hA, apply d_t=0101, d_f=1010 with no spacer -> err=1, ack=0.
REQ-041 Scenario, reset mid-handshake: rst pulsed while ack=1 with the codeword held -> all outputs 0 immediately; no valid until a spacer and then a new codeword are applied.
REQ-042 Scenario, counter saturation and clear: four errors -> err_cnt=3; clr=1 -> err_cnt=0; clr coincident with an error entry -> err_cnt=0.
